// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed A/D bus sequencer: arbitrates single-register writes against a
// periodic 9-register read-back scan and generates the CS/RD/WR/A-D strobe timing.
module rtc_bus_sequencer #(
  parameter int T_PHASE     = 4,
  parameter int REFRESH_DIV = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic [3:0] rd_idx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel
);

  localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0]     PH_LAST  = 4'(T_PHASE - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0]     IDX_LAST = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_DATA,
    S_RECOV
  } state_t;

  state_t         state, state_next;
  logic [3:0]     phase;
  logic           phase_last;
  logic [CW-1:0]  refresh_cnt;
  logic           wrap;
  logic           scan_pending, scan_active;
  logic [3:0]     scan_idx;
  logic [3:0]     grant_idx;
  logic [7:0]     lat_addr, lat_data, samp;
  logic           lat_write;
  logic           grant_write, grant_read;
  logic           data_end, recov_end;

  function automatic logic [7:0] scan_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    scan_addr = 8'h21;
      4'd1:    scan_addr = 8'h22;
      4'd2:    scan_addr = 8'h23;
      4'd3:    scan_addr = 8'h24;
      4'd4:    scan_addr = 8'h25;
      4'd5:    scan_addr = 8'h26;
      4'd6:    scan_addr = 8'h41;
      4'd7:    scan_addr = 8'h42;
      4'd8:    scan_addr = 8'h43;
      default: scan_addr = 8'h00;
    endcase
  endfunction

  assign phase_last  = (phase == PH_LAST);
  assign wrap        = (refresh_cnt == CNT_LAST);
  // A write still held high in its own ack cycle must not be granted twice.
  assign grant_write = (state == S_IDLE) && wr_req && !wr_ack;
  assign grant_read  = (state == S_IDLE) && !grant_write && (scan_active || scan_pending);
  assign grant_idx   = scan_active ? scan_idx : 4'd0;
  assign data_end    = (state == S_DATA) && phase_last;
  assign recov_end   = (state == S_RECOV) && phase_last;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= 4'd0;
    end else begin
      state <= state_next;
      if (state_next != state || state == S_IDLE) phase <= 4'd0;
      else                                        phase <= phase + 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    ad_sel     = 1'b0;
    ad_oe      = 1'b0;
    ad_out     = 8'h00;
    case (state)
      S_IDLE: begin
        if (grant_write || grant_read) state_next = S_ADDR;
      end
      S_ADDR: begin
        cs_n   = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = lat_addr;
        if (phase_last) state_next = S_GAP;
      end
      S_GAP: begin
        ad_sel = 1'b1;
        if (phase_last) state_next = S_DATA;
      end
      S_DATA: begin
        cs_n   = 1'b0;
        ad_sel = 1'b1;
        if (lat_write) begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = lat_data;
        end else begin
          rd_n   = 1'b0;
        end
        if (phase_last) state_next = S_RECOV;
      end
      S_RECOV: begin
        ad_sel = 1'b1;
        if (phase_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt  <= '0;
      scan_pending <= 1'b0;
      scan_active  <= 1'b0;
      scan_idx     <= 4'd0;
      lat_addr     <= 8'h00;
      lat_data     <= 8'h00;
      lat_write    <= 1'b0;
      samp         <= 8'h00;
      wr_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_idx       <= 4'd0;
      rd_data      <= 8'h00;
    end else begin
      wr_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      refresh_cnt <= wrap ? '0 : refresh_cnt + CW'(1);

      if (grant_write) begin
        lat_addr  <= wr_addr;
        lat_data  <= wr_data;
        lat_write <= 1'b1;
      end else if (grant_read) begin
        lat_addr  <= scan_addr(grant_idx);
        lat_write <= 1'b0;
      end

      // Wraps while a scan is running are dropped rather than queued.
      if (grant_read && !scan_active) begin
        scan_active  <= 1'b1;
        scan_idx     <= 4'd0;
        scan_pending <= 1'b0;
      end else if (wrap && !scan_active) begin
        scan_pending <= 1'b1;
      end

      if (data_end && !lat_write) samp <= ad_in;

      if (recov_end) begin
        if (lat_write) begin
          wr_ack <= 1'b1;
        end else begin
          rd_valid <= 1'b1;
          rd_idx   <= scan_idx;
          rd_data  <= samp;
          if (scan_idx == IDX_LAST) scan_active <= 1'b0;
          else                      scan_idx    <= scan_idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: scoreboard of expected completions,
// bus model answering reads with addr^0xFF, per-phase strobe checks.
module tb_rtc_bus_sequencer;
  localparam int TP   = 4;
  localparam int RDIV = 64;
  localparam int LAT  = 1 + 4 * TP;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, rd_valid, busy, ad_oe, cs_n, rd_n, wr_n, ad_sel;
  logic [3:0] rd_idx;
  logic [7:0] rd_data, ad_out, ad_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_wr;
    logic [3:0] idx;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] scan_exp [9] = '{8'hDE, 8'hDD, 8'hDC, 8'hDB, 8'hDA, 8'hD9, 8'hBE, 8'hBD, 8'hBC};

  always #5 clock = ~clock;

  rtc_bus_sequencer #(.T_PHASE(TP), .REFRESH_DIV(RDIV)) dut (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .ad_sel(ad_sel)
  );

  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  // RTC bus model: latch address on the address cycle, answer reads with its complement.
  logic [7:0] bus_addr = 8'h00;
  always @(posedge clock) if (!cs_n && !ad_sel && ad_oe) bus_addr <= ad_out;
  assign ad_in = bus_addr ^ 8'hFF;

  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      if ((!rd_n && !wr_n) || (ad_oe && !rd_n)) begin
        n_fail++;
        $display("FAIL strobe_exclusive: rd_n=%0b wr_n=%0b ad_oe=%0b at cycle %0d", rd_n, wr_n, ad_oe, cyc);
      end
    end
  end

  task automatic next_event(input int budget, output bit is_wr, output logic [3:0] idx,
                            output logic [7:0] data, output int at, output bit ok);
    ok = 0; is_wr = 0; idx = '0; data = '0; at = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (wr_ack || rd_valid) begin
        ok = 1; is_wr = wr_ack; idx = rd_idx; data = rd_data; at = cyc;
      end
    end
  endtask

  task automatic test_reset;
    int first;
    reset = 1'b1; wr_req = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({cs_n, rd_n, wr_n, ad_sel, ad_oe, ad_out} !== {5'b11100, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_bus: got cs/rd/wr/sel/oe=%b ad_out=%h, expected 11100 00",
               {cs_n, rd_n, wr_n, ad_sel, ad_oe}, ad_out);
    end
    n_checks++;
    if ({wr_ack, rd_valid, busy, rd_idx, rd_data} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_status: got ack=%0b valid=%0b busy=%0b idx=%0d data=%h, expected all 0",
               wr_ack, rd_valid, busy, rd_idx, rd_data);
    end
    reset = 1'b0;
    first = -1;
    for (int k = 0; k < 200 && first < 0; k++) begin
      @(negedge clock);
      if (busy) first = cyc;
    end
    n_checks++;
    if (first !== RDIV + 1) begin
      n_fail++;
      $display("FAIL first_scan_grant: busy first seen at cycle %0d, expected %0d", first, RDIV + 1);
    end
    n_checks++;
    if ({cs_n, ad_sel, ad_oe, ad_out} !== {3'b001, 8'h21}) begin
      n_fail++;
      $display("FAIL first_scan_addr: got cs/sel/oe=%b ad_out=%h, expected 001 21",
               {cs_n, ad_sel, ad_oe}, ad_out);
    end
  endtask

  task automatic test_full_scan;
    bit w, ok; logic [3:0] i; logic [7:0] d; int at; exp_t e;
    for (int k = 0; k < 9; k++) exp_q.push_back('{1'b0, 4'(k), scan_exp[k]});
    for (int k = 0; k < 9; k++) begin
      next_event(40, w, i, d, at, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL full_scan_timeout: no completion in 40 cycles, expected idx %0d", e.idx);
      end else if (w !== e.is_wr || i !== e.idx || d !== e.data) begin
        n_fail++;
        $display("FAIL full_scan_event: got wr=%0b idx=%0d data=%h, expected wr=%0b idx=%0d data=%h",
                 w, i, d, e.is_wr, e.idx, e.data);
      end
      if (k == 0) begin
        n_checks++;
        if (at !== RDIV + LAT) begin
          n_fail++;
          $display("FAIL full_scan_latency: idx0 valid at cycle %0d, expected %0d", at, RDIV + LAT);
        end
      end
    end
    while (cyc < 240) begin
      @(negedge clock);
      n_checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_idle: busy=%0b rd_valid=%0b at cycle %0d, expected 0 0", busy, rd_valid, cyc);
      end
    end
  endtask

  task automatic test_single_write;
    int g, ph; logic [3:0] exp_ctl; logic [7:0] exp_out; exp_t e;
    g = cyc;
    wr_addr = 8'h23; wr_data = 8'h15; wr_req = 1'b1;
    exp_q.push_back('{1'b1, 4'd0, 8'h00});
    for (int p = 1; p <= 4 * TP; p++) begin
      @(negedge clock);
      ph = (p - 1) / TP;
      exp_ctl = (ph == 0 || ph == 2) ? 4'b0011 : 4'b1110;
      n_checks++;
      if ({cs_n, wr_n, rd_n, ad_oe} !== exp_ctl || busy !== 1'b1 || wr_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL write_phase%0d: got cs/wr/rd/oe=%b busy=%0b ack=%0b, expected %b 1 0",
                 p, {cs_n, wr_n, rd_n, ad_oe}, busy, wr_ack, exp_ctl);
      end
      if (ph == 0 || ph == 2) begin
        exp_out = (ph == 0) ? 8'h23 : 8'h15;
        n_checks++;
        if (ad_out !== exp_out || ad_sel !== (ph == 2)) begin
          n_fail++;
          $display("FAIL write_bus%0d: got ad_out=%h ad_sel=%0b, expected %h %0b",
                   p, ad_out, ad_sel, exp_out, ph == 2);
        end
      end
    end
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++;
    if (wr_ack !== e.is_wr || cyc !== g + LAT) begin
      n_fail++;
      $display("FAIL write_ack: got wr_ack=%0b at cycle %0d, expected 1 at %0d", wr_ack, cyc, g + LAT);
    end
    @(negedge clock);
    n_checks++;
    if (wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ack_pulse: wr_ack=%0b one cycle after ack, expected 0", wr_ack);
    end
    wr_req = 1'b0;
  endtask

  task automatic test_write_during_scan;
    bit w, ok; logic [3:0] i; logic [7:0] d; int at; exp_t e;
    for (int k = 0; k < 3; k++) exp_q.push_back('{1'b0, 4'(k), scan_exp[k]});
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        @(negedge clock);
        wr_addr = 8'h41; wr_data = 8'h30; wr_req = 1'b1;
        exp_q.push_back('{1'b0, 4'd3, scan_exp[3]});
        exp_q.push_back('{1'b1, 4'd0, 8'h00});
        for (int j = 4; j < 9; j++) exp_q.push_back('{1'b0, 4'(j), scan_exp[j]});
      end
      next_event(40, w, i, d, at, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL interleave_timeout: event %0d missing, expected wr=%0b idx=%0d", k, e.is_wr, e.idx);
      end else if (w !== e.is_wr || (!e.is_wr && (i !== e.idx || d !== e.data))) begin
        n_fail++;
        $display("FAIL interleave_event%0d: got wr=%0b idx=%0d data=%h, expected wr=%0b idx=%0d data=%h",
                 k, w, i, d, e.is_wr, e.idx, e.data);
      end
      if (ok && w) begin
        @(negedge clock);
        wr_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_vs_refresh;
    bit w, ok, found; logic [3:0] i; logic [7:0] d; int at, g; exp_t e;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clock);
      if ((cyc % RDIV) == RDIV - 1) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL refresh_wait: wrap cycle not reached, cycle %0d", cyc);
    end
    g = cyc;
    wr_addr = 8'h26; wr_data = 8'h99; wr_req = 1'b1;
    exp_q.push_back('{1'b1, 4'd0, 8'h00});
    for (int k = 0; k < 9; k++) exp_q.push_back('{1'b0, 4'(k), scan_exp[k]});
    for (int k = 0; k < 10; k++) begin
      next_event(40, w, i, d, at, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL race_timeout: event %0d missing, expected wr=%0b idx=%0d", k, e.is_wr, e.idx);
      end else if (w !== e.is_wr || (!e.is_wr && (i !== e.idx || d !== e.data))) begin
        n_fail++;
        $display("FAIL race_event%0d: got wr=%0b idx=%0d data=%h, expected wr=%0b idx=%0d data=%h",
                 k, w, i, d, e.is_wr, e.idx, e.data);
      end
      if (k < 2) begin
        n_checks++;
        if (at !== g + (k + 1) * LAT) begin
          n_fail++;
          $display("FAIL race_timing%0d: event at cycle %0d, expected %0d", k, at, g + (k + 1) * LAT);
        end
      end
      if (ok && w) begin
        @(negedge clock);
        wr_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_write;
    bit w, ok; logic [3:0] i; logic [7:0] d; int at; exp_t e;
    @(negedge clock);
    wr_addr = 8'h30; wr_data = 8'h5A; wr_req = 1'b1;
    repeat (2 * TP + 2) @(negedge clock);
    n_checks++;
    if ({cs_n, wr_n, ad_oe, ad_out} !== {3'b001, 8'h5A}) begin
      n_fail++;
      $display("FAIL abort_data: got cs/wr/oe=%b ad_out=%h, expected 001 5a", {cs_n, wr_n, ad_oe}, ad_out);
    end
    reset = 1'b1; wr_req = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({cs_n, rd_n, wr_n, ad_oe, busy, wr_ack} !== 6'b111000) begin
      n_fail++;
      $display("FAIL abort_strobes: got cs/rd/wr/oe/busy/ack=%b, expected 111000",
               {cs_n, rd_n, wr_n, ad_oe, busy, wr_ack});
    end
    reset = 1'b0; wr_req = 1'b1;
    exp_q.push_back('{1'b1, 4'd0, 8'h00});
    next_event(40, w, i, d, at, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || w !== e.is_wr || at !== LAT) begin
      n_fail++;
      $display("FAIL rerequest_ack: got ok=%0b wr=%0b at cycle %0d, expected 1 1 at %0d", ok, w, at, LAT);
    end
    @(negedge clock);
    wr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_single_write();
    test_write_during_scan();
    test_write_vs_refresh();
    test_reset_mid_write();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected events left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
